// File: rtl/icache_pkg.sv
// icache_pkg
// Shared definitions for the instruction-cache refill controller:
// FSM state encoding, line geometry, beat counter width and the
// byte-offset mask used to line-align fetch addresses.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_BEATS  = 3'd2,
    ST_FILL   = 3'd3,
    ST_REPLAY = 3'd4
  } state_t;

  localparam int          LINE_WORDS       = 4;
  localparam int          LINE_BITS        = 128;
  localparam int          BEAT_CNT_W       = 2;
  localparam logic [31:0] LINE_OFFSET_MASK = 32'hF;

endpackage

// File: rtl/icache_line_buf.sv
// icache_line_buf
// Beat counter plus word-insert register that assembles one cache line
// from in-order 32-bit memory beats.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   clear       restart assembly at word 0 (line contents are kept)
//   write       store data into word [beat_cnt] and advance the counter
//   data        32-bit beat data
//   line        assembled line, word k in bits [32k+31:32k]
//   beat_cnt    index of the word the next write lands in
module icache_line_buf
  import icache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  clear,
  input  logic                  write,
  input  logic [31:0]           data,
  output logic [LINE_BITS-1:0]  line,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  logic [BEAT_CNT_W-1:0] cnt_reg;

  // The counter wraps naturally after the last word, which is exactly the
  // beat that hands the line over to the fill cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (write) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign beat_cnt = cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [31:0] word_reg;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          word_reg <= '0;
        end else if (write && (cnt_reg == BEAT_CNT_W'(gi))) begin
          word_reg <= data;
        end
      end

      assign line[gi*32 +: 32] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// Miss/refill controller for the direct-mapped instruction cache. On an
// IDLE miss it stalls fetch, requests the 4-word line from memory, collects
// the beats, writes the assembled line into the cache for one cycle, waits
// one replay cycle and returns to IDLE where the hit is re-evaluated.
// Optional feature macro: ICACHE_PERF_CNT_EN enables the hit/miss counters;
// without it hit_cnt and miss_cnt are constant zero.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   fetch_valid/fetch_addr     fetch request from the fetch stage
//   cache_hit                  same-cycle hit flag for fetch_addr
//   stall                      hold PC/fetch
//   mem_req/mem_addr/mem_gnt   line read request handshake
//   mem_rvalid/mem_rdata       in-order data beats, word 0 first
//   fill_we/fill_addr/fill_line  one-cycle cache line write
//   hit_cnt/miss_cnt           performance counters
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 fetch_valid,
  input  logic [ADDR_W-1:0]    fetch_addr,
  input  logic                 cache_hit,
  output logic                 stall,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic                 fill_we,
  output logic [ADDR_W-1:0]    fill_addr,
  output logic [LINE_BITS-1:0] fill_line,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     addr_reg;
  logic                  start_miss;
  logic                  buf_write;
  logic [BEAT_CNT_W-1:0] beat_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_miss = 1'b0;
    buf_write  = 1'b0;
    mem_req    = 1'b0;
    fill_we    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fetch_valid && !cache_hit) begin
          start_miss = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_next = ST_BEATS;
      end
      ST_BEATS: begin
        if (mem_rvalid) begin
          buf_write = 1'b1;
          if (beat_cnt == BEAT_CNT_W'(LINE_WORDS - 1)) state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_we    = 1'b1;
        state_next = ST_REPLAY;
      end
      ST_REPLAY: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // In IDLE the stall follows the live miss so the PC is held in the very
  // cycle the miss is seen; in every other state it is purely state-driven.
  assign stall = (state_reg == ST_IDLE) ? (fetch_valid && !cache_hit) : 1'b1;

  // The latched line address is authoritative for the whole refill; later
  // fetch_addr changes are not looked at until the FSM is back in IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_reg <= '0;
    end else if (start_miss) begin
      addr_reg <= fetch_addr & ~ADDR_W'(LINE_OFFSET_MASK);
    end
  end

  assign mem_addr  = addr_reg;
  assign fill_addr = addr_reg;

  icache_line_buf u_line_buf (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clear    (start_miss),
    .write    (buf_write),
    .data     (mem_rdata),
    .line     (fill_line),
    .beat_cnt (beat_cnt)
  );

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && fetch_valid && cache_hit) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      if (start_miss) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule
